fifo_reader_check: RTL and testbench

FIFO_READER_CHECK -- requirements
Module: fifo_reader_check

---
 rtl/fifo_reader_check.sv | 136 +++++++++++++
 tb/tb_fifo_reader_check.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader_check.sv
// fifo_reader_check: paced FIFO drain that checks the read stream against
// the write-side LFSR sequence. One word is read per IDLE->REQ->WAIT->DONE
// pass; each word is compared with the expected value, counted, and the
// expected register resynchronises to the received word.
//
// Handshake: o_read is a one-cycle request, high only in REQ. The FIFO RAM
// presents i_data on the following cycle (WAIT), and it is sampled on the
// edge that leaves WAIT. o_valid is high for the single DONE cycle that
// follows, while o_data holds the word just captured. There is no
// back-pressure on o_valid.
module fifo_reader_check #(
    parameter int                DATA_W = 24,
    parameter int                PACE   = 50_000_000,
    parameter logic [DATA_W-1:0] SEED   = 24'h5AC26C
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_step,
    input  logic              i_notempty,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_read,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [15:0]       o_count,
    output logic [7:0]        o_err_count,
    output logic              o_err,
    output logic              o_busy,
    output logic [1:0]        o_dbg_state
);

    localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [PW-1:0]     r_pace;
    logic              w_pace_done;
    logic              w_trigger;
    logic              r_read;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_exp;
    logic [15:0]       r_count;
    logic [7:0]        r_err_count;
    logic              r_err;

    // Write-side generator step: x^24+x^23+x^22+x^17+1, shifting left.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
        return {x[DATA_W-2:0], x[23] ^ x[22] ^ x[21] ^ x[16]};
    endfunction

    assign w_pace_done = (r_pace == PW'(PACE - 1));

    // A trigger without data available is simply not taken: the step pulse
    // is lost and the saturated pace counter keeps pace_done asserted.
    assign w_trigger = (r_state == S_IDLE) && i_notempty &&
                       ((i_en && w_pace_done) || i_step);

    // State register.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: only IDLE waits; the rest advance every cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_state_next = S_REQ;
            S_REQ:   w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pace counter: counts up in IDLE and saturates at PACE-1; restarts
    // from zero as each read completes so reads are PACE+3 cycles apart.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_pace <= '0;
        end else if (r_state == S_DONE) begin
            r_pace <= '0;
        end else if ((r_state == S_IDLE) && !w_pace_done) begin
            r_pace <= r_pace + PW'(1);
        end
    end

    // Read request, output strobe, capture, sequence check and counters.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_read      <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_exp       <= SEED;
            r_count     <= '0;
            r_err_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_read  <= w_trigger;
            r_valid <= (r_state == S_WAIT);
            if (r_state == S_WAIT) begin
                r_data  <= i_data;
                r_count <= r_count + 16'd1;
                if (i_data != r_exp) begin
                    r_err <= 1'b1;
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                // Resync on the received word so a dropped word costs one error.
                r_exp <= lfsr_next(i_data);
            end
        end
    end

    assign o_read      = r_read;
    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_count     = r_count;
    assign o_err_count = r_err_count;
    assign o_err       = r_err;
    assign o_busy      = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_reader_check.sv
// Directed bench for fifo_reader_check (PACE=4, SEED=1). A responder plays
// the FIFO RAM and pushes every word it serves into exp_q; a monitor pops
// exp_q on each o_valid and compares data and counters with a small model.
module tb_fifo_reader_check;

    localparam int          DATA_W = 24;
    localparam int          PACE   = 4;
    localparam logic [23:0] SEED   = 24'h000001;

    // Clock and reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset      = 1'b1;
    logic              i_en       = 1'b0;
    logic              i_step     = 1'b0;
    logic              i_notempty = 1'b0;
    logic [DATA_W-1:0] i_data     = '0;
    logic              o_read;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic [15:0]       o_count;
    logic [7:0]        o_err_count;
    logic              o_err;
    logic              o_busy;
    logic [1:0]        o_dbg_state;

    fifo_reader_check #(
        .DATA_W (DATA_W),
        .PACE   (PACE),
        .SEED   (SEED)
    ) dut (
        .i_clk       (clk),
        .reset       (reset),
        .i_en        (i_en),
        .i_step      (i_step),
        .i_notempty  (i_notempty),
        .i_data      (i_data),
        .o_read      (o_read),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_count     (o_count),
        .o_err_count (o_err_count),
        .o_err       (o_err),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_reads = 0;
    int n_valid = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] data_q[$];

    // Reference model of the checker state.
    logic [DATA_W-1:0] m_exp = SEED;
    logic [15:0]       m_cnt = '0;
    logic [7:0]        m_err = '0;

    bit                src_bad     = 1'b0;
    bit                chk_spacing = 1'b0;
    bit                chk_first   = 1'b0;
    bit                have_last   = 1'b0;
    int                last_cyc    = 0;
    int                rel_cyc     = 0;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_pop;

    function automatic logic [23:0] lfsr_next(input logic [23:0] x);
        return {x[22:0], x[23] ^ x[22] ^ x[21] ^ x[16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO RAM responder: serves a word the cycle after each read request.
    always @(negedge clk) begin
        if (o_read) begin
            n_reads++;
            if (chk_first) begin
                chk("first_read_delay",
                    32'(((cyc - rel_cyc) >= PACE - 1) && ((cyc - rel_cyc) <= PACE)), 32'd1);
                chk_first = 1'b0;
            end
            if (chk_spacing && have_last) begin
                chk("read_spacing", 32'(cyc - last_cyc), 32'(PACE + 3));
            end
            last_cyc  = cyc;
            have_last = 1'b1;
            if (data_q.size() > 0) r_word = data_q.pop_front();
            else if (src_bad)      r_word = m_exp ^ 24'h000001;
            else                   r_word = m_exp;
            i_data = r_word;
            exp_q.push_back(r_word);
            if (r_word != m_exp && m_err != 8'hFF) m_err = m_err + 8'd1;
            m_exp = lfsr_next(r_word);
            m_cnt = m_cnt + 16'd1;
        end
    end

    // Scoreboard monitor: every o_valid must match the next queued word.
    always @(negedge clk) begin
        if (!reset && o_valid) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_underflow", 32'd1, 32'd0);
            end else begin
                r_pop = exp_q.pop_front();
                chk("sb_data", 32'(o_data), 32'(r_pop));
            end
            chk("sb_count", 32'(o_count), 32'(m_cnt));
            chk("sb_err_count", 32'(o_err_count), 32'(m_err));
            n_valid++;
        end
    end

    // Driver tasks.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_model();
        exp_q.delete();
        data_q.delete();
        m_exp     = SEED;
        m_cnt     = '0;
        m_err     = '0;
        have_last = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        clear_model();
        tick(n);
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_valids(input int target, input int budget);
        int k = 0;
        while (n_valid < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("valid_timeout", 32'(n_valid >= target), 32'd1);
    endtask

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence.
    initial begin
        int          r0;
        int          nv;
        logic [23:0] w2, w3, w4, w5;

        // Reset state while reset is held.
        tick(3);
        chk("rst_read", 32'(o_read), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_err_count", 32'(o_err_count), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'd0);
        reset = 1'b0;
        tick(1);

        // Single step: read at T+1, valid at T+3.
        i_notempty = 1'b1;
        i_step     = 1'b1;
        tick(1);
        i_step = 1'b0;
        chk("step_read_t1", 32'(o_read), 32'd1);
        chk("step_busy_t1", 32'(o_busy), 32'd1);
        tick(1);
        chk("step_read_t2", 32'(o_read), 32'd0);
        chk("step_valid_t2", 32'(o_valid), 32'd0);
        tick(1);
        chk("step_valid_t3", 32'(o_valid), 32'd1);
        chk("step_data_t3", 32'(o_data), 32'h000001);
        chk("step_count_t3", 32'(o_count), 32'd1);
        chk("step_err_t3", 32'(o_err), 32'd0);
        tick(1);
        chk("step_valid_t4", 32'(o_valid), 32'd0);
        chk("step_busy_t4", 32'(o_busy), 32'd0);

        // A step pulse while in WAIT is ignored.
        r0     = n_reads;
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        tick(1);
        chk("ign_in_wait", 32'(o_dbg_state), 32'd2);
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        tick(6);
        chk("ign_reads", 32'(n_reads - r0), 32'd1);
        chk("ign_count", 32'(o_count), 32'd2);

        // Empty FIFO blocks paced reads.
        i_notempty = 1'b0;
        i_en       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("empty_read", 32'(o_read), 32'd0);
            chk("empty_busy", 32'(o_busy), 32'd0);
        end
        nv         = n_valid;
        i_notempty = 1'b1;
        tick(1);
        chk("empty_release_read", 32'(o_read), 32'd1);
        i_en = 1'b0;
        wait_valids(nv + 1, 10);

        // Correct stream of 10 words at PACE+3 spacing.
        i_en = 1'b1;
        do_reset(2);
        chk_first   = 1'b1;
        chk_spacing = 1'b1;
        nv          = n_valid;
        wait_valids(nv + 10, 120);
        i_en        = 1'b0;
        chk_spacing = 1'b0;
        chk("stream_count", 32'(o_count), 32'd10);
        chk("stream_err_count", 32'(o_err_count), 32'd0);
        chk("stream_err", 32'(o_err), 32'd0);
        tick(8);

        // Dropped word: w3 never arrives.
        do_reset(2);
        w2 = lfsr_next(SEED);
        w3 = lfsr_next(w2);
        w4 = lfsr_next(w3);
        w5 = lfsr_next(w4);
        data_q.push_back(SEED);
        data_q.push_back(w2);
        data_q.push_back(w4);
        data_q.push_back(w5);
        nv   = n_valid;
        i_en = 1'b1;
        wait_valids(nv + 4, 60);
        i_en = 1'b0;
        chk("drop_err_count", 32'(o_err_count), 32'd1);
        chk("drop_err", 32'(o_err), 32'd1);
        chk("drop_count", 32'(o_count), 32'd4);
        chk("drop_last_data", 32'(o_data), 32'(w5));
        tick(8);

        // Reset while in WAIT discards the in-flight word.
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        chk("mid_req_state", 32'(o_dbg_state), 32'd1);
        tick(1);
        chk("mid_wait_state", 32'(o_dbg_state), 32'd2);
        reset = 1'b1;
        clear_model();
        tick(1);
        chk("mid_state", 32'(o_dbg_state), 32'd0);
        chk("mid_count", 32'(o_count), 32'd0);
        chk("mid_valid", 32'(o_valid), 32'd0);
        chk("mid_read", 32'(o_read), 32'd0);
        chk("mid_err", 32'(o_err), 32'd0);
        reset = 1'b0;
        tick(1);
        chk("mid_valid_after", 32'(o_valid), 32'd0);
        nv     = n_valid;
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        wait_valids(nv + 1, 10);
        chk("mid_seed_data", 32'(o_data), 32'(SEED));
        chk("mid_seed_err", 32'(o_err), 32'd0);
        chk("mid_seed_count", 32'(o_count), 32'd1);
        tick(4);

        // Error counter saturation over 300 mismatching words.
        do_reset(2);
        src_bad = 1'b1;
        nv      = n_valid;
        i_en    = 1'b1;
        wait_valids(nv + 300, 2600);
        i_en    = 1'b0;
        src_bad = 1'b0;
        chk("sat_err_count", 32'(o_err_count), 32'hFF);
        chk("sat_count", 32'(o_count), 32'd300);
        chk("sat_err", 32'(o_err), 32'd1);
        tick(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
